reg_file_pair: RTL and testbench
================================

Name: reg_file_pair

Overview:
- Parametrised general-purpose register file for the tinySoC core. It replaces the fixed 16x8 file.
- Provides one synchronous write port, two combinational read ports and a register-pair port.
- The pair port performs increment, decrement or signed-offset add on a 2*DATA_W-bit register pair in one cycle, and reports wrap status.
- Sits between the decoder/ALU and memory-address logic; pairs serve as pointers.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 4, register address width; NREG = 2**ADDR_W registers, NREG/2 pairs.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_sel  input  ADDR_W  write register index.
- wr_data  input  DATA_W  write data.
- wr_en  input  1  write strobe.
- rd_a_sel  input  ADDR_W  read port A index.
- rd_b_sel  input  ADDR_W  read port B index.
- rd_a  output  DATA_W  combinational contents of rFile[rd_a_sel].
- rd_b  output  DATA_W  combinational contents of rFile[rd_b_sel].
- pair_sel  input  ADDR_W-1  pair index p; low byte is reg 2p, high byte is reg 2p+1.
- pair_op  input  2  00 none, 01 inc, 10 dec, 11 add pair_off.
- pair_off  input  DATA_W  signed offset, sign-extended to 2*DATA_W for op 11.
- pair_out  output  2*DATA_W  combinational {rFile[2p+1], rFile[2p]}.
- pair_wrap  output  1  registered; 1 if the last pair op wrapped modulo 2**(2*DATA_W).
- pair_zero  output  1  registered; 1 if the last pair op result was 0.

Behaviour:
- Reset:
  - rst high at a clock edge sets every register, pair_wrap and pair_zero to 0.
  - rst overrides any wr_en or pair_op in that cycle.
  - rd_a, rd_b and pair_out read 0 from the following cycle.
- Reads:
  - Reads are asynchronous and show pre-edge contents.
  - There is no write-through: data written at edge N appears on the read ports after edge N.
- Write: when wr_en=1, rFile[wr_sel] <= wr_data at the edge.
- Pair op, with P = {rFile[2p+1], rFile[2p]} as unsigned 2*DATA_W:
  - inc: R = P+1.
  - dec: R = P-1.
  - add: R = P + sext(pair_off).
  - All arithmetic is modulo 2**(2*DATA_W).
  - Both halves are written with R in one cycle.
  - Carry propagates from the low byte to the high byte; this is full 16-bit arithmetic at default parameters.
- pair_wrap:
  - inc: set when P = all-ones.
  - dec: set when P = 0.
  - add, positive offset: set on unsigned carry out.
  - add, negative offset: set on no borrow-free result, i.e. when P < |off|.
  - add with offset 0: never set.
- Flag update:
  - pair_wrap and pair_zero update only on cycles with pair_op != 00 and rst = 0.
  - Both flags hold otherwise.
  - Both flags are computed from R before any write-port override (see Conflict).
- Conflict, when wr_en=1 and wr_sel is 2p or 2p+1 in the same cycle as a pair op:
  - The write port wins for that register.
  - The other half still receives its half of R.
  - Flags still reflect the full R.
- Latency: one cycle for writes and pair ops; zero for reads.
- No internal state other than the register array and the two flag bits.
- The block has no FSM states.
- The block never stalls.

Test Plan:
- Reset: preload r3=0x5A, assert rst with wr_en=1 and pair_op=01 -> next cycle all rd ports 0, pair_wrap=0, pair_zero=0, r3=0.
- Carry inc: r4=0xFF, r5=0x12, pair_sel=2, op=01 -> pair_out=0x1300, pair_wrap=0, pair_zero=0.
- Wrap inc/dec:
  - Pair 0 = 0xFFFF, inc -> 0x0000 with wrap=1 and zero=1.
  - Then dec -> 0xFFFF with wrap=1 and zero=0.
  - Then an idle cycle -> flags hold.
- Signed add:
  - Pair 1 = 0x0100, off=0xFE (-2) -> 0x00FE, wrap=0.
  - Pair 1 = 0x0001, off=0xFE -> 0xFFFF, wrap=1.
  - Pair 1 = 0xFFF0, off=0x20 -> 0x0010, wrap=1.
- Conflict:
  - Pair 3 = 0x00FF, inc with wr_sel=6, wr_data=0xAA -> r6=0xAA, r7=0x01, pair_wrap=0.
  - Same with wr_sel=7, wr_data=0x55 -> r7=0x55, r6=0x00.
- Parameter sweep:
  - DATA_W=16, ADDR_W=3: pair 0 = 0x0000_FFFF, inc -> 0x0001_0000.
  - Read ports A and B on the same index return identical data.
  - Write then read next cycle returns the written value.

Source files
------------

// File: rtl/reg_file_pair.sv
// -----------------------------------------------------------------------------
// reg_file_pair
//   General-purpose register file for the tinySoC core. It has one synchronous
//   write port and two combinational read ports. Its register-pair port can
//   increment, decrement or add a signed offset to a 2*DATA_W-bit pair in a
//   single cycle. Two registered flags report the status of the last pair op.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    register address width; 2**ADDR_W registers, half as many pairs
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   wr_en      write strobe
//   wr_sel     write register index
//   wr_data    write data
//   rd_a_sel   read port A index
//   rd_a       combinational read data, port A
//   rd_b_sel   read port B index
//   rd_b       combinational read data, port B
//   pair_sel   pair index p (low half = reg 2p, high half = reg 2p+1)
//   pair_op    00 none, 01 inc, 10 dec, 11 add sign-extended pair_off
//   pair_off   signed offset used by the add operation
//   pair_out   combinational {reg 2p+1, reg 2p}
//   pair_wrap  registered; the last pair op wrapped modulo 2**(2*DATA_W)
//   pair_zero  registered; the last pair op produced zero
// -----------------------------------------------------------------------------
module reg_file_pair #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     rd_a_sel,
  output logic [DATA_W-1:0]     rd_a,
  input  logic [ADDR_W-1:0]     rd_b_sel,
  output logic [DATA_W-1:0]     rd_b,
  input  logic [ADDR_W-2:0]     pair_sel,
  input  logic [1:0]            pair_op,
  input  logic [DATA_W-1:0]     pair_off,
  output logic [2*DATA_W-1:0]   pair_out,
  output logic                  pair_wrap,
  output logic                  pair_zero
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int PW   = 2 * DATA_W;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_ADD  = 2'b11
  } pair_op_e;

  logic [DATA_W-1:0] rfile_q [NREG];
  logic [DATA_W-1:0] rfile_d [NREG];
  logic              wrap_q, wrap_d;
  logic              zero_q, zero_d;

  pair_op_e          op;
  logic [ADDR_W-1:0] lo_idx, hi_idx;
  logic [PW-1:0]     pair_val;
  logic [PW-1:0]     addend;
  logic              addend_neg;
  logic [PW:0]       sum;

  assign op     = pair_op_e'(pair_op);
  assign lo_idx = {pair_sel, 1'b0};
  assign hi_idx = {pair_sel, 1'b1};

  // Reads are straight from the array, so they always show pre-edge contents.
  assign rd_a     = rfile_q[rd_a_sel];
  assign rd_b     = rfile_q[rd_b_sel];
  assign pair_val = {rfile_q[hi_idx], rfile_q[lo_idx]};
  assign pair_out = pair_val;

  // Every op is P plus an addend. Decrement adds all-ones, and add uses the
  // sign-extended offset. Adding a negative addend in two's complement carries
  // out exactly when no wrap occurred, so wrap is the carry flipped for
  // negative addends. This covers inc (P = max), dec (P = 0), positive and
  // negative offsets, and offset 0 (never wraps).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    addend     = '0;
    addend_neg = 1'b0;
    unique case (op)
      OP_INC: addend = PW'(1);
      OP_DEC: begin
        addend     = '1;
        addend_neg = 1'b1;
      end
      OP_ADD: begin
        addend     = {{DATA_W{pair_off[DATA_W-1]}}, pair_off};
        addend_neg = pair_off[DATA_W-1];
      end
      default: ;
    endcase
  end

  assign sum = {1'b0, pair_val} + {1'b0, addend};

  always_comb begin
    rfile_d = rfile_q;
    wrap_d  = wrap_q;
    zero_d  = zero_q;
    if (op != OP_NONE) begin
      rfile_d[lo_idx] = sum[DATA_W-1:0];
      rfile_d[hi_idx] = sum[PW-1:DATA_W];
      // Flags come from the full result, even if the write port replaces a half.
      wrap_d          = sum[PW] ^ addend_neg;
      zero_d          = (sum[PW-1:0] == '0);
    end
    // NOTE: blocking order matters here; this later assignment lets the write port win a conflict.
    if (wr_en) begin
      rfile_d[wr_sel] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is reset explicitly; the core relies on every register reading 0 after reset.
      for (int i = 0; i < NREG; i++) begin
        rfile_q[i] <= '0;
      end
      wrap_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      rfile_q <= rfile_d;
      wrap_q  <= wrap_d;
      zero_q  <= zero_d;
    end
  end

  assign pair_wrap = wrap_q;
  assign pair_zero = zero_q;

endmodule

// File: tb/tb_reg_file_pair.sv
// -----------------------------------------------------------------------------
// tb_reg_file_pair
//   Self-checking bench for reg_file_pair. A behavioural model tracks the
//   default (8/4) instance, and the outputs are compared with it on every
//   cycle. Directed vectors add literal expectations. A second instance with
//   DATA_W=16 and ADDR_W=3 covers the wider parameter set.
// -----------------------------------------------------------------------------
module tb_reg_file_pair;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_sel = '0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  rd_a_sel = '0;
  logic [3:0]  rd_b_sel = '0;
  logic [7:0]  rd_a, rd_b;
  logic [2:0]  pair_sel = '0;
  logic [1:0]  pair_op = '0;
  logic [7:0]  pair_off = '0;
  logic [15:0] pair_out;
  logic        pair_wrap, pair_zero;

  logic        w_en16 = 1'b0;
  logic [2:0]  w_sel16 = '0;
  logic [15:0] w_data16 = '0;
  logic [2:0]  a_sel16 = '0;
  logic [2:0]  b_sel16 = '0;
  logic [15:0] rd_a16, rd_b16;
  logic [1:0]  p_sel16 = '0;
  logic [1:0]  p_op16 = '0;
  logic [15:0] p_off16 = '0;
  logic [31:0] p_out16;
  logic        p_wrap16, p_zero16;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reg_file_pair #(.DATA_W(8), .ADDR_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_a_sel(rd_a_sel), .rd_a(rd_a), .rd_b_sel(rd_b_sel), .rd_b(rd_b),
    .pair_sel(pair_sel), .pair_op(pair_op), .pair_off(pair_off),
    .pair_out(pair_out), .pair_wrap(pair_wrap), .pair_zero(pair_zero)
  );

  reg_file_pair #(.DATA_W(16), .ADDR_W(3)) u_dut16 (
    .clk(clk), .rst(rst),
    .wr_en(w_en16), .wr_sel(w_sel16), .wr_data(w_data16),
    .rd_a_sel(a_sel16), .rd_a(rd_a16), .rd_b_sel(b_sel16), .rd_b(rd_b16),
    .pair_sel(p_sel16), .pair_op(p_op16), .pair_off(p_off16),
    .pair_out(p_out16), .pair_wrap(p_wrap16), .pair_zero(p_zero16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: each pair is an integer. The result is P + delta, and
  // any excursion outside [0, 2**16) counts as a wrap.
  logic [7:0] m_reg [16];
  logic       m_wrap, m_zero;

  always @(posedge clk) begin : model
    int p, r, delta;
    bit w;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 8'h00;
      m_wrap <= 1'b0;
      m_zero <= 1'b0;
    end else begin
      if (pair_op != 2'b00) begin
        p = {m_reg[2*pair_sel+1], m_reg[2*pair_sel]};
        case (pair_op)
          2'b01:   delta = 1;
          2'b10:   delta = -1;
          default: delta = $signed(pair_off);
        endcase
        r = p + delta;
        w = (r < 0) || (r > 65535);
        r = (r + 65536) % 65536;
        m_reg[2*pair_sel]   <= r[7:0];
        m_reg[2*pair_sel+1] <= r[15:8];
        m_wrap <= w;
        m_zero <= (r == 0);
      end
      if (wr_en) m_reg[wr_sel] <= wr_data;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_rd_a", 32'(rd_a), 32'(m_reg[rd_a_sel]));
      check("m_rd_b", 32'(rd_b), 32'(m_reg[rd_b_sel]));
      check("m_pair_out", 32'(pair_out), 32'({m_reg[2*pair_sel+1], m_reg[2*pair_sel]}));
      check("m_pair_wrap", 32'(pair_wrap), 32'(m_wrap));
      check("m_pair_zero", 32'(pair_zero), 32'(m_zero));
    end
  end

  // Apply one vector, let one rising edge pass, then return 2 time units later.
  // The new outputs are then settled and can be sampled.
  task automatic drive(input logic r, input logic we, input logic [3:0] ws,
                       input logic [7:0] wd, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] ps, input logic [1:0] op, input logic [7:0] off);
    rst = r; wr_en = we; wr_sel = ws; wr_data = wd;
    rd_a_sel = a; rd_b_sel = b; pair_sel = ps; pair_op = op; pair_off = off;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [3:0] ws, input logic [7:0] wd);
    drive(1'b0, 1'b1, ws, wd, ws, ws, 3'd0, 2'b00, 8'h00);
  endtask

  task automatic pop(input logic [2:0] ps, input logic [1:0] op, input logic [7:0] off);
    drive(1'b0, 1'b0, 4'd0, 8'h00, {ps, 1'b0}, {ps, 1'b1}, ps, op, off);
  endtask

  initial begin
    // Reset, then enable the per-cycle comparison.
    drive(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 3'd0, 2'b00, 8'h00);
    cmp_en = 1'b1;

    // The reset must override a write and a pair op that arrive in the same cycle.
    wr(4'd3, 8'h5A);
    check("wr_then_rd", 32'(rd_a), 32'h5A);
    drive(1'b1, 1'b1, 4'd3, 8'h77, 4'd3, 4'd2, 3'd1, 2'b01, 8'h00);
    check("rst_rd_a", 32'(rd_a), 32'h0);
    check("rst_rd_b", 32'(rd_b), 32'h0);
    check("rst_pair_out", 32'(pair_out), 32'h0);
    check("rst_wrap", 32'(pair_wrap), 32'h0);
    check("rst_zero", 32'(pair_zero), 32'h0);

    // Increment with a carry from the low byte into the high byte.
    wr(4'd4, 8'hFF);
    wr(4'd5, 8'h12);
    pop(3'd2, 2'b01, 8'h00);
    check("carry_inc", 32'(pair_out), 32'h1300);
    check("carry_inc_wrap", 32'(pair_wrap), 32'h0);
    check("carry_inc_zero", 32'(pair_zero), 32'h0);

    // Wrap on increment and on decrement, then the flags must hold while idle.
    wr(4'd0, 8'hFF);
    wr(4'd1, 8'hFF);
    pop(3'd0, 2'b01, 8'h00);
    check("inc_wrap_val", 32'(pair_out), 32'h0000);
    check("inc_wrap", 32'(pair_wrap), 32'h1);
    check("inc_zero", 32'(pair_zero), 32'h1);
    pop(3'd0, 2'b10, 8'h00);
    check("dec_wrap_val", 32'(pair_out), 32'hFFFF);
    check("dec_wrap", 32'(pair_wrap), 32'h1);
    check("dec_zero", 32'(pair_zero), 32'h0);
    wr(4'd9, 8'h3C);
    check("idle_wrap_hold", 32'(pair_wrap), 32'h1);
    check("idle_zero_hold", 32'(pair_zero), 32'h0);

    // Signed offset add on pair 1.
    wr(4'd2, 8'h00); wr(4'd3, 8'h01);
    pop(3'd1, 2'b11, 8'hFE);
    check("add_neg_val", 32'(pair_out), 32'h00FE);
    check("add_neg_wrap", 32'(pair_wrap), 32'h0);
    wr(4'd2, 8'h01); wr(4'd3, 8'h00);
    pop(3'd1, 2'b11, 8'hFE);
    check("add_neg_uf_val", 32'(pair_out), 32'hFFFF);
    check("add_neg_uf_wrap", 32'(pair_wrap), 32'h1);
    wr(4'd2, 8'hF0); wr(4'd3, 8'hFF);
    pop(3'd1, 2'b11, 8'h20);
    check("add_pos_of_val", 32'(pair_out), 32'h0010);
    check("add_pos_of_wrap", 32'(pair_wrap), 32'h1);
    pop(3'd1, 2'b11, 8'h00);
    check("add_zero_off_val", 32'(pair_out), 32'h0010);
    check("add_zero_off_wrap", 32'(pair_wrap), 32'h0);
    wr(4'd2, 8'h02); wr(4'd3, 8'h00);
    pop(3'd1, 2'b11, 8'hFE);
    check("add_to_zero_zero", 32'(pair_zero), 32'h1);
    check("add_to_zero_wrap", 32'(pair_wrap), 32'h0);

    // Write port conflicts with a pair op on pair 3.
    wr(4'd6, 8'hFF); wr(4'd7, 8'h00);
    drive(1'b0, 1'b1, 4'd6, 8'hAA, 4'd6, 4'd7, 3'd3, 2'b01, 8'h00);
    check("conf_lo_r6", 32'(rd_a), 32'hAA);
    check("conf_lo_r7", 32'(rd_b), 32'h01);
    check("conf_lo_wrap", 32'(pair_wrap), 32'h0);
    wr(4'd6, 8'hFF); wr(4'd7, 8'h00);
    drive(1'b0, 1'b1, 4'd7, 8'h55, 4'd6, 4'd7, 3'd3, 2'b01, 8'h00);
    check("conf_hi_r6", 32'(rd_a), 32'h00);
    check("conf_hi_r7", 32'(rd_b), 32'h55);
    wr(4'd6, 8'hFF); wr(4'd7, 8'hFF);
    drive(1'b0, 1'b1, 4'd6, 8'hAA, 4'd6, 4'd7, 3'd3, 2'b01, 8'h00);
    check("conf_full_r6", 32'(rd_a), 32'hAA);
    check("conf_full_r7", 32'(rd_b), 32'h00);
    check("conf_full_wrap", 32'(pair_wrap), 32'h1);
    check("conf_full_zero", 32'(pair_zero), 32'h1);

    // Address sweep: write distinct data everywhere, then read it all back.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'hC0 ^ (i * 7)));
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 4'd0, 8'h00, 4'(i), 4'(15 - i), 3'(i % 8), 2'b00, 8'h00);
      check("sweep_rd_a", 32'(rd_a), 32'(8'(8'hC0 ^ (i * 7))));
      check("sweep_rd_b", 32'(rd_b), 32'(8'(8'hC0 ^ ((15 - i) * 7))));
    end

    // Wider instance: a 32-bit pair carries across the 16-bit halves.
    w_en16 = 1'b1; w_sel16 = 3'd0; w_data16 = 16'hFFFF;
    @(posedge clk); #2;
    w_sel16 = 3'd1; w_data16 = 16'h0000;
    @(posedge clk); #2;
    w_en16 = 1'b0; p_sel16 = 2'd0; p_op16 = 2'b01;
    @(posedge clk); #2;
    p_op16 = 2'b00; a_sel16 = 3'd1; b_sel16 = 3'd1;
    #1;
    check("w16_inc", p_out16, 32'h0001_0000);
    check("w16_wrap", 32'(p_wrap16), 32'h0);
    check("w16_zero", 32'(p_zero16), 32'h0);
    check("w16_rd_a", 32'(rd_a16), 32'h0001);
    check("w16_rd_b", 32'(rd_b16), 32'h0001);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
